// File: rtl/clock_divider_pkg.sv
// clock_divider_pkg: shared ratio type, minimum ratio and half-period helper
package clock_divider_pkg;

    typedef logic [7:0] ratio_t;

    localparam int RATIO_MIN = 2;

    function automatic ratio_t half(input ratio_t n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clock_divider_phase_counter.sv
// clock_divider_phase_counter: phase register counting 0..N-1, flags the period boundary
module clock_divider_phase_counter
    import clock_divider_pkg::*;
#(
    parameter ratio_t RST_PHASE = 8'd1
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  ratio_t n_cur_i,
    output logic   wrap_o,
    output ratio_t phase_next_o
);

    ratio_t r_phase;

    assign wrap_o       = (r_phase == n_cur_i - 8'd1);
    assign phase_next_o = wrap_o ? '0 : r_phase + 8'd1;

    // Reset parks the phase on the last slot so the first edge is a boundary
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_phase <= RST_PHASE;
        else        r_phase <= phase_next_o;
    end

endmodule

// File: rtl/clock_divider.sv
// clock_divider: two-ratio integer clock divider with boundary-aligned ratio switching
// Optional tick_o pulse at each period start when CLOCK_DIVIDER_TICK_EN is defined
module clock_divider
    import clock_divider_pkg::*;
#(
    parameter int DIV_A = 2,
    parameter int DIV_B = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       selector_i,
    output logic       clk_o,
    output logic [7:0] res_o,
    output logic       pending_o
`ifdef CLOCK_DIVIDER_TICK_EN
    ,
    output logic       tick_o
`endif
);

    localparam ratio_t RA = ratio_t'(DIV_A);
    localparam ratio_t RB = ratio_t'(DIV_B);

    generate
        if (DIV_A < RATIO_MIN || DIV_B < RATIO_MIN || DIV_A > 255 || DIV_B > 255) begin : g_bad_ratio
            $error("clock_divider: DIV_A and DIV_B must lie in 2..255");
        end
    endgenerate

    logic   r_sel_q;
    ratio_t r_n_cur;
    logic   r_clk;
    ratio_t r_res;
    logic   w_wrap;
    ratio_t w_phase_next;
    ratio_t w_n_sel;
    ratio_t w_n_next;

    // The ratio only changes at a boundary, using the selector sampled in that cycle
    assign w_n_sel  = r_sel_q ? RB : RA;
    assign w_n_next = w_wrap ? w_n_sel : r_n_cur;

    clock_divider_phase_counter #(
        .RST_PHASE(RA - 8'd1)
    ) u_phase_counter (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .n_cur_i     (r_n_cur),
        .wrap_o      (w_wrap),
        .phase_next_o(w_phase_next)
    );

    // Selector sampling, active ratio, divided clock and period count
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_sel_q <= 1'b0;
            r_n_cur <= RA;
            r_clk   <= 1'b0;
            r_res   <= '0;
        end else begin
            r_sel_q <= selector_i;
            r_n_cur <= w_n_next;
            r_clk   <= (w_phase_next < half(w_n_next));
            if (w_wrap) r_res <= r_res + 8'd1;
        end
    end

    assign clk_o     = r_clk;
    assign res_o     = r_res;
    assign pending_o = (w_n_sel != r_n_cur);

`ifdef CLOCK_DIVIDER_TICK_EN
    logic r_tick;

    // A boundary edge loads phase 0, so the tick is simply the registered boundary flag
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_tick <= 1'b0;
        else        r_tick <= w_wrap;
    end

    assign tick_o = r_tick;
`endif

endmodule

// File: tb/tb_clock_divider.sv
// tb_clock_divider: directed self-checking bench for clock_divider
module tb_clock_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sel_a = 1'b0;
    logic       sel_c = 1'b0;
    logic       sel_e = 1'b0;
    logic       clk_a, clk_c, clk_e;
    logic [7:0] res_a, res_c, res_e;
    logic       pend_a, pend_c, pend_e;
    int         checks = 0;
    int         errors = 0;
`ifdef CLOCK_DIVIDER_TICK_EN
    logic       tick_a, tick_c, tick_e;
`endif

    always #5 clk = ~clk;

    clock_divider #(.DIV_A(2), .DIV_B(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .selector_i(sel_a),
        .clk_o(clk_a), .res_o(res_a), .pending_o(pend_a)
`ifdef CLOCK_DIVIDER_TICK_EN
        , .tick_o(tick_a)
`endif
    );

    clock_divider #(.DIV_A(2), .DIV_B(5)) dut_c (
        .clk_i(clk), .rst_i(rst), .selector_i(sel_c),
        .clk_o(clk_c), .res_o(res_c), .pending_o(pend_c)
`ifdef CLOCK_DIVIDER_TICK_EN
        , .tick_o(tick_c)
`endif
    );

    clock_divider #(.DIV_A(3), .DIV_B(3)) dut_e (
        .clk_i(clk), .rst_i(rst), .selector_i(sel_e),
        .clk_o(clk_e), .res_o(res_e), .pending_o(pend_e)
`ifdef CLOCK_DIVIDER_TICK_EN
        , .tick_o(tick_e)
`endif
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        sel_a = 1'b0;
        sel_c = 1'b1;
        sel_e = 1'b0;
        rst   = 1'b0;
        step();
        step();
        checks++;
        if (clk_a !== 1'b0 || res_a !== 8'd0 || pend_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_a got clk=%0b res=%0d pend=%0b exp 0 0 0", clk_a, res_a, pend_a);
        end
        checks++;
        if (clk_c !== 1'b0 || res_c !== 8'd0 || pend_c !== 1'b0) begin
            errors++;
            $display("FAIL reset_c got clk=%0b res=%0d pend=%0b exp 0 0 0", clk_c, res_c, pend_c);
        end
        rst = 1'b1;
    endtask

    // Edge k after release: dut_a runs N=2; dut_c runs one N=2 period then N=5
    task automatic test_div;
        logic       e_clk, e_pend;
        logic [7:0] e_res;
        for (int k = 1; k <= 13; k++) begin
            step();
            e_clk = k[0];
            e_res = 8'((k + 1) / 2);
            checks++;
            if (clk_a !== e_clk || res_a !== e_res || pend_a !== 1'b0) begin
                errors++;
                $display("FAIL div_a k=%0d got clk=%0b res=%0d pend=%0b exp %0b %0d 0", k, clk_a, res_a, pend_a, e_clk, e_res);
            end
            e_clk  = (k < 3) ? (k == 1) : (((k - 3) % 5) < 2);
            e_res  = (k < 3) ? 8'd1 : 8'(2 + (k - 3) / 5);
            e_pend = (k < 3);
            checks++;
            if (clk_c !== e_clk || res_c !== e_res || pend_c !== e_pend) begin
                errors++;
                $display("FAIL div_c k=%0d got clk=%0b res=%0d pend=%0b exp %0b %0d %0b", k, clk_c, res_c, pend_c, e_clk, e_res, e_pend);
            end
        end
    endtask

    // Continues from edge 13 (phase 0 of an N=2 period, res=7)
    task automatic test_switch;
        logic       e_clk, e_pend;
        logic [7:0] e_res;
        sel_a = 1'b1;
        checks++;
        if (pend_a !== 1'b0) begin
            errors++;
            $display("FAIL switch_pend_early got %0b exp 0", pend_a);
        end
        for (int j = 0; j < 9; j++) begin
            step();
            e_clk  = (j == 0) ? 1'b0 : (((j - 1) % 4) < 2);
            e_res  = (j == 0) ? 8'd7 : 8'(8 + (j - 1) / 4);
            e_pend = (j == 0);
            checks++;
            if (clk_a !== e_clk || res_a !== e_res || pend_a !== e_pend) begin
                errors++;
                $display("FAIL switch j=%0d got clk=%0b res=%0d pend=%0b exp %0b %0d %0b", j, clk_a, res_a, pend_a, e_clk, e_res, e_pend);
            end
        end
    endtask

    // Selector high only when sampled at boundary edge 3, so sel_q=1 is seen at non-boundary edge 4
    task automatic test_revert;
        logic       e_clk;
        logic [7:0] e_res;
        sel_a = 1'b0;
        do_reset();
        step();
        step();
        sel_a = 1'b1;
        step();
        sel_a = 1'b0;
        checks++;
        if (pend_a !== 1'b1 || clk_a !== 1'b1) begin
            errors++;
            $display("FAIL revert_e3 got pend=%0b clk=%0b exp 1 1", pend_a, clk_a);
        end
        for (int k = 4; k <= 9; k++) begin
            step();
            e_clk = k[0];
            e_res = 8'((k + 1) / 2);
            checks++;
            if (clk_a !== e_clk || res_a !== e_res || pend_a !== 1'b0) begin
                errors++;
                $display("FAIL revert k=%0d got clk=%0b res=%0d pend=%0b exp %0b %0d 0", k, clk_a, res_a, pend_a, e_clk, e_res);
            end
        end
    endtask

    task automatic test_wrap;
        logic [7:0] e_res;
        sel_a = 1'b0;
        do_reset();
        for (int k = 1; k <= 511; k++) begin
            step();
            if (k >= 509) begin
                e_res = 8'(((k + 1) / 2) % 256);
                checks++;
                if (res_a !== e_res) begin
                    errors++;
                    $display("FAIL wrap k=%0d got res=%0d exp %0d", k, res_a, e_res);
                end
            end
        end
    endtask

    task automatic test_async_reset;
        sel_a = 1'b1;
        do_reset();
        step();
        step();
        step();
        sel_a = 1'b0;
        checks++;
        if (clk_a !== 1'b1 || res_a !== 8'd2) begin
            errors++;
            $display("FAIL arst_pre got clk=%0b res=%0d exp 1 2", clk_a, res_a);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (clk_a !== 1'b0 || res_a !== 8'd0 || pend_a !== 1'b0) begin
            errors++;
            $display("FAIL arst_now got clk=%0b res=%0d pend=%0b exp 0 0 0", clk_a, res_a, pend_a);
        end
        #2 rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (clk_a !== k[0] || res_a !== 8'((k + 1) / 2)) begin
                errors++;
                $display("FAIL arst_after k=%0d got clk=%0b res=%0d exp %0b %0d", k, clk_a, res_a, k[0], (k + 1) / 2);
            end
        end
    endtask

    task automatic test_equal;
        logic       e_clk;
        logic [7:0] e_res;
        sel_e = 1'b0;
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            sel_e = ~sel_e;
            step();
            e_clk = ((k - 1) % 3) == 0;
            e_res = 8'((k + 2) / 3);
            checks++;
            if (clk_e !== e_clk || res_e !== e_res || pend_e !== 1'b0) begin
                errors++;
                $display("FAIL equal k=%0d got clk=%0b res=%0d pend=%0b exp %0b %0d 0", k, clk_e, res_e, pend_e, e_clk, e_res);
            end
        end
    endtask

`ifdef CLOCK_DIVIDER_TICK_EN
    task automatic test_tick;
        sel_a = 1'b0;
        do_reset();
        checks++;
        if (tick_a !== 1'b0) begin
            errors++;
            $display("FAIL tick_reset got %0b exp 0", tick_a);
        end
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (tick_a !== k[0]) begin
                errors++;
                $display("FAIL tick k=%0d got %0b exp %0b", k, tick_a, k[0]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_div();
        test_switch();
        test_revert();
        test_wrap();
        test_async_reset();
        test_equal();
`ifdef CLOCK_DIVIDER_TICK_EN
        test_tick();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_divider.md
# clock_divider

Integer clock divider: the divide-down counterpart of the clock multiplier. From the single system clock it generates a registered divided clock/enable `clk_o` with one of two compile-time ratios, chosen at run time by `selector_i`. Ratio changes are applied only at an output-period boundary, so `clk_o` never produces a runt pulse. An 8-bit period counter `res_o` is provided for observation in benches and on-board debug.

## Interface
- `DIV_A`, 2, divide ratio when `selector_i`=0; integer, 2..255.
- `DIV_B`, 4, divide ratio when `selector_i`=1; integer, 2..255.
- `clk_i`  in  1  system clock; all logic on its rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `selector_i`  in  1  ratio select; 0 selects DIV_A, 1 selects DIV_B; synchronous to `clk_i`.
- `clk_o`  out  1  divided clock, registered.
- `res_o`  out  8  count of output periods started, wrapping.
- `pending_o`  out  1  high while a requested ratio differs from the active ratio.
- `tick_o`  out  1  one-cycle pulse at each period start; present only with `CLOCK_DIVIDER_TICK_EN`.

## Operation
- Registers:
  - `sel_q`: registered `selector_i`.
  - `n_cur`: active ratio N, 8 bit.
  - `phase`: 8 bit, counts 0..N-1.
  - `clk_o`, `res_o`.
- Reset values while `rst_i`=0:
  - `sel_q`=0, `n_cur`=DIV_A, `phase`=DIV_A-1.
  - `clk_o`=0, `res_o`=0, `pending_o`=0, `tick_o`=0.
- Each cycle with `rst_i`=1:
  - `sel_q` <= `selector_i`.
  - If `phase`==`n_cur`-1, this is a boundary: `phase` <= 0, `res_o` <= `res_o`+1 (mod 256), and `n_cur` <= (`sel_q` ? DIV_B : DIV_A).
  - Otherwise `phase` <= `phase`+1.
- `clk_o` <= (`phase_next` < `n_cur_next`/2), using integer division. It is high for phases 0..N/2-1 and low for the rest. Duty cycle is 50% for even N and floor(N/2)/N for odd N.
- `pending_o` = ((`sel_q` ? DIV_B : DIV_A) != `n_cur`). It is combinational from registers.
- A selector toggle that reverts before the next boundary produces no ratio change. Only the `sel_q` value sampled at the boundary cycle matters.
- Rules when DIV_A==DIV_B:
  - `pending_o` is permanently 0.
  - `clk_o` is unaffected by `selector_i`.
- Reset asserted mid-period returns every register to its reset value immediately, with no glitch on `clk_o` beyond the forced 0.

## Timing
- First rising edge after reset release is a boundary: `phase`=0, `clk_o`=1, `res_o`=1.
- Output period is exactly N `clk_i` cycles.
- Ratio change latency:
  - `selector_i` to `sel_q` takes 1 cycle.
  - The new ratio is applied at the next boundary. Worst case is 1+N_old cycles.
- Boundary rules:
  - The first period after a change uses the new N in full.
  - The last period before the change completes with the old N.
- `res_o` wraps 255 -> 0 on the 256th boundary.

## Configuration
- `CLOCK_DIVIDER_TICK_EN` defined:
  - `tick_o` is a registered output, high for exactly the one cycle in which `phase`==0.
  - This includes the first cycle after reset release.
- `CLOCK_DIVIDER_TICK_EN` undefined:
  - The `tick_o` port and its logic are absent.
  - All other behaviour is identical.

## Structure
- Package `clock_divider_pkg`:
  - `ratio_t` typedef (logic [7:0]).
  - `RATIO_MIN`=2 constant.
  - Function `half(ratio_t)` returning N/2.
- Elaboration-time assertion: DIV_A and DIV_B must be ≥ RATIO_MIN.
- Sub-module `phase_counter`: holds `phase`, compares against `n_cur`, and outputs `wrap` and `phase_next`.
- The top level holds `sel_q`, `n_cur`, `clk_o`, `res_o` and `tick_o`.

## Test plan
- Reset release, `selector_i`=0, defaults -> `clk_o` toggles every cycle (1,0,1,0); `res_o` increments every 2 cycles; `pending_o`=0.
- After 3 periods set `selector_i`=1 mid-period -> `pending_o` rises 1 cycle later; at the next boundary `clk_o` becomes 1,1,0,0 with period 4; `pending_o` falls at that boundary.
- DIV_B=5, `selector_i`=1 from reset -> `clk_o` pattern 1,1,0,0,0 repeating; `res_o` increments every 5 cycles.
- Toggle `selector_i` 0->1->0 within one DIV_B=4 period while running on DIV_A=2 -> no ratio change; period stays 2.
- Run 256 boundaries -> `res_o` wraps 255 -> 0.
- Assert `rst_i`=0 asynchronously mid-high phase -> `clk_o`=0, `res_o`=0 and `n_cur`=DIV_A immediately; after release, the first edge gives `clk_o`=1, `res_o`=1.
- With `CLOCK_DIVIDER_TICK_EN`, DIV_A=2 -> `tick_o` pulses on every other cycle, coincident with `clk_o` going high.
